// File: rtl/alu_dispatch.sv
// Request dispatcher for a bank of start/done ALU units: one request in flight, result returned
// on a valid/ready port. Optional WAIT watchdog compiled in with ALU_DISPATCH_TIMEOUT_EN.
module alu_dispatch #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OP_W-1:0]         req_op,
  input  logic [7:0]              req_a,
  input  logic [7:0]              req_b,
  output logic [7:0]              unit_a,
  output logic [7:0]              unit_b,
  output logic [NUM_UNITS-1:0]    unit_start,
  input  logic [NUM_UNITS-1:0]    unit_done,
  input  logic [16*NUM_UNITS-1:0] unit_res,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_res,
  output logic                    rsp_err,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [7:0]            a_q, a_d, b_q, b_d;
  logic [15:0]           res_q, res_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [NUM_UNITS-1:0]  start_q, start_d;
  logic                  done_sel;
  logic [15:0]           res_sel;
  logic                  op_ok;
  logic                  timeout_hit;

  assign op_ok = 32'(req_op) < NUM_UNITS;

  // Only the selected unit's done/result matter; other units' pulses are ignored.
  always_comb begin
    done_sel = 1'b0;
    res_sel  = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (op_q == OP_W'(i)) begin
        done_sel = unit_done[i];
        res_sel  = unit_res[16*i +: 16];
      end
    end
  end

`ifdef ALU_DISPATCH_TIMEOUT_EN
  logic [7:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (state_q == StIssue) begin
      timer_d = '0;
    end else if (state_q == StWait) begin
      timer_d = timer_q + 8'd1;
    end
  end

  // timer_q counts completed WAIT cycles, so TIMEOUT-1 marks the last allowed one.
  assign timeout_hit = (state_q == StWait) && (timer_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (op_ok) begin
            state_d = StIssue;
          end else begin
            state_d = StResp;
            res_d   = '0;
            err_d   = 1'b1;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // done takes priority over a timeout expiring on the same edge
        if (done_sel) begin
          state_d = StResp;
          res_d   = res_sel;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = StResp;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are decoded from the upcoming state.
  always_comb begin
    start_d = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      start_d[i] = (state_d == StIssue) && (op_d == OP_W'(i));
    end
    valid_d = (state_d == StResp);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end

  assign req_ready  = (state_q == StIdle) && !rst;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign unit_start = start_q;
  assign rsp_valid  = valid_q;
  assign rsp_res    = res_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: table vectors, random traffic against a transaction-level model,
// and hand sequences for stray done, mid-WAIT reset, stall and (if compiled in) timeout.
module tb_alu_dispatch;

  localparam int NU = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [3:0]    req_op;
  logic [7:0]    req_a, req_b, unit_a, unit_b;
  logic [NU-1:0] unit_start, unit_done, auto_done, man_done;
  logic [16*NU-1:0] unit_res, auto_res, man_res;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [15:0]   rsp_res;
  bit            auto_en;

  int total = 0;
  int bad   = 0;

  assign unit_done = auto_done | man_done;
  assign unit_res  = auto_res | man_res;

  alu_dispatch dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .unit_a(unit_a), .unit_b(unit_b), .unit_start(unit_start),
    .unit_done(unit_done), .unit_res(unit_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behaviour of the attached units (external to the DUT).
  function automatic logic [15:0] unit_fn(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0:       return {8'h00, a & b};
      1:       return {8'h00, a | b};
      2:       return 16'(a) + 16'(b);
      default: return 16'(a) * 16'(b);
    endcase
  endfunction

  // Standard unit: samples start at E1, done visible after E2 for one cycle.
  initial begin
    int idx;
    logic [7:0] ua, ub;
    auto_done = '0;
    auto_res  = '0;
    forever begin
      @(negedge clk);
      if (auto_en && unit_start != 0) begin
        idx = 0;
        for (int i = 0; i < NU; i++) if (unit_start[i]) idx = i;
        ua = unit_a;
        ub = unit_b;
        @(posedge clk);
        @(posedge clk);
        #1;
        auto_done[idx] = 1'b1;
        auto_res[16*idx +: 16] = unit_fn(idx, ua, ub);
        @(posedge clk);
        #1;
        auto_done = '0;
        auto_res  = '0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full request/response transaction with response checks and optional rsp_ready stall.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int stall, input logic [15:0] eres, input logic eerr, input int elat);
    int lat, starts;
    logic [NU-1:0] sval, estart;
    bit got;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    rsp_ready = (stall == 0);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; starts = 0; sval = '0; got = 0;
    while (!got && lat < 60) begin
      if (unit_start != 0) begin
        starts++;
        sval = unit_start;
        chk("unit_a", 32'(unit_a), 32'(a));
        chk("unit_b", 32'(unit_b), 32'(b));
      end
      if (rsp_valid) got = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("rsp_seen", 32'(got), 1);
    if (!got) begin
      do_reset();
      return;
    end
    estart = (op < NU) ? (4'b0001 << op) : 4'b0000;
    chk("start_count", 32'(starts), (op < NU) ? 1 : 0);
    chk("start_val", 32'(sval), 32'(estart));
    chk("latency", 32'(lat), 32'(elat));
    chk("rsp_res", 32'(rsp_res), 32'(eres));
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_res", 32'(rsp_res), 32'(eres));
      chk("stall_err", 32'(rsp_err), 32'(eerr));
      chk("stall_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("back_idle_valid", 32'(rsp_valid), 0);
    chk("back_idle_ready", 32'(req_ready), 1);
  endtask

  // Accept a request without the unit model; returns at the ISSUE-cycle negedge.
  task automatic man_accept(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a, b;
    logic [15:0] res;
    logic        err;
    int          lat;
    int          stall;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int vcount;
    logic [3:0] rop;
    logic [7:0] ra, rb;
    vecs[0] = '{4'd0,  8'hF0, 8'h3C, 16'h0030, 1'b0, 4, 0};
    vecs[1] = '{4'd1,  8'hF0, 8'h0F, 16'h00FF, 1'b0, 4, 0};
    vecs[2] = '{4'd2,  8'hFF, 8'h01, 16'h0100, 1'b0, 4, 0};
    vecs[3] = '{4'd3,  8'h10, 8'h10, 16'h0100, 1'b0, 4, 0};
    vecs[4] = '{4'd3,  8'hFF, 8'hFF, 16'hFE01, 1'b0, 4, 0};
    vecs[5] = '{4'd5,  8'h12, 8'h34, 16'h0000, 1'b1, 1, 0};
    vecs[6] = '{4'd15, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1, 0};
    vecs[7] = '{4'd2,  8'h80, 8'h80, 16'h0100, 1'b0, 4, 10};
    vecs[8] = '{4'd4,  8'hAA, 8'h55, 16'h0000, 1'b1, 1, 3};

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; man_done = '0; man_res = '0; auto_en = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_start", 32'(unit_start), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].res, vecs[i].err,
           vecs[i].lat);

    // Random traffic against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (rop < NU) send(rop, ra, rb, $urandom_range(0, 2), unit_fn(int'(rop), ra, rb), 1'b0, 4);
      else          send(rop, ra, rb, $urandom_range(0, 2), 16'h0000, 1'b1, 1);
    end

    // Stray done while idle produces nothing.
    auto_en = 1'b0;
    @(negedge clk);
    man_done = 4'b1111;
    @(negedge clk);
    man_done = '0;
    vcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || busy) vcount++;
    end
    chk("idle_stray_done", 32'(vcount), 0);

    // Done from unit 2 ignored while waiting on unit 1.
    man_accept(4'd1, 8'h0A, 8'hA0);
    chk("issue_start_u1", 32'(unit_start), 32'h2);
    @(negedge clk);
    man_done = 4'b0100; man_res[32 +: 16] = 16'h1234;
    @(negedge clk);
    man_done = '0; man_res = '0;
    @(negedge clk);
    chk("other_done_ignored", 32'(rsp_valid), 0);
    man_done = 4'b0010; man_res[16 +: 16] = 16'h00AA;
    @(negedge clk);
    man_done = '0; man_res = '0;
    chk("u1_valid", 32'(rsp_valid), 1);
    chk("u1_res", 32'(rsp_res), 32'h00AA);
    chk("u1_err", 32'(rsp_err), 0);
    @(negedge clk);
    chk("u1_idle", 32'(req_ready), 1);

    // Asynchronous reset mid-WAIT.
    man_accept(4'd2, 8'h55, 8'h66);
    @(negedge clk);
    chk("wait_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_start", 32'(unit_start), 0);
    chk("arst_a", 32'(unit_a), 0);
    chk("arst_b", 32'(unit_b), 0);
    chk("arst_valid", 32'(rsp_valid), 0);
    chk("arst_res", 32'(rsp_res), 0);
    chk("arst_err", 32'(rsp_err), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    auto_en = 1'b1;
    send(4'd2, 8'h55, 8'h66, 0, 16'h00BB, 1'b0, 4);
    auto_en = 1'b0;

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // No done: abort after 15 WAIT cycles, response at negedge 17 after accept.
    man_accept(4'd0, 8'h11, 8'h22);
    vcount = 1;
    while (!rsp_valid && vcount < 60) begin
      @(negedge clk);
      vcount++;
    end
    chk("to_latency", 32'(vcount), 17);
    chk("to_res", 32'(rsp_res), 0);
    chk("to_err", 32'(rsp_err), 1);
    @(negedge clk);
    man_done = 4'b0001; man_res[0 +: 16] = 16'h5A5A;
    @(negedge clk);
    man_done = '0; man_res = '0;
    vcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) vcount++;
    end
    chk("late_done_ignored", 32'(vcount), 0);

    // Done on the timeout edge wins.
    man_accept(4'd1, 8'h01, 8'h02);
    repeat (15) @(negedge clk);
    man_done = 4'b0010; man_res[16 +: 16] = 16'hC0DE;
    @(negedge clk);
    man_done = '0; man_res = '0;
    chk("tie_valid", 32'(rsp_valid), 1);
    chk("tie_res", 32'(rsp_res), 32'hC0DE);
    chk("tie_err", 32'(rsp_err), 0);
    @(negedge clk);
`else
    // Without the watchdog, WAIT persists until done.
    man_accept(4'd3, 8'h11, 8'h22);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || !busy) vcount++;
    end
    chk("no_timeout_wait", 32'(vcount), 0);
    man_done = 4'b1000; man_res[48 +: 16] = 16'hBEEF;
    @(negedge clk);
    man_done = '0; man_res = '0;
    chk("late_valid", 32'(rsp_valid), 1);
    chk("late_res", 32'(rsp_res), 32'hBEEF);
    chk("late_err", 32'(rsp_err), 0);
    @(negedge clk);
`endif
    chk("final_idle", 32'(req_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Initiator side of the ALU unit start/done protocol: accepts one operation request at a time from upstream, issues a one-cycle `start` to the selected ALU unit, waits for that unit's `done` pulse, captures its 16-bit result, and returns it on a valid/ready response port. It sits between the top-level ALU controller and the bank of per-operation units (AND, OR, ADD, ...), each of which samples `a`/`b` after `start` and pulses `done` with `res` valid for exactly one cycle.

## Interface
- `NUM_UNITS`, 4, number of attached ALU units; legal 1..16.
- `OP_W`, 4, width of the opcode field; must satisfy 2^OP_W >= NUM_UNITS.
- `TIMEOUT`, 15, maximum WAIT cycles before abort; legal 1..255. Used only with the timeout configuration compiled in.

- `clk` in 1 — single clock; all logic on the rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `req_valid` in 1 — upstream request present.
- `req_ready` out 1 — block can accept a request.
- `req_op` in OP_W — unit index to execute.
- `req_a`, `req_b` in 8 each — operands.
- `unit_a`, `unit_b` out 8 each — operands broadcast to all units.
- `unit_start` out NUM_UNITS — one-hot start pulse.
- `unit_done` in NUM_UNITS — per-unit done pulse.
- `unit_res` in 16*NUM_UNITS — flattened results; unit i at bits [16i+15:16i].
- `rsp_valid` out 1 — response present.
- `rsp_ready` in 1 — downstream accepts the response.
- `rsp_res` out 16 — captured result.
- `rsp_err` out 1 — invalid opcode or timeout.
- `busy` out 1 — high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1 (forced 0 while `rst` high). On `req_valid`: latch op, a, b into registers.
  - If op >= NUM_UNITS, go to RESP with `rsp_res`=16'h0000 and `rsp_err`=1. No unit is started.
  - Otherwise, go to ISSUE.
- ISSUE: lasts exactly one cycle. `unit_start[op]`=1 and all other bits are 0. `unit_a`/`unit_b` drive the latched operands. Clear the timer, then go to WAIT.
- WAIT: `unit_start`=0. `unit_a`/`unit_b` stay stable.
  - When `unit_done[op]` is sampled high: capture the `unit_res` slice for op into `rsp_res`, set `rsp_err`=0, go to RESP.
  - `unit_done` bits of other units are ignored.
- RESP: `rsp_valid`=1. `rsp_res` and `rsp_err` are held stable until `rsp_ready` is sampled high, then go to IDLE. Holding `rsp_ready` low stalls indefinitely.
- Only one request is outstanding at a time. `req_ready`=0 in ISSUE, WAIT and RESP.
- `unit_done` is ignored outside WAIT, including late pulses after a timeout.
- Reset (asynchronous, any state), all outputs return to their reset values:
  - state IDLE, `unit_start`=0, `unit_a`=`unit_b`=0.
  - `rsp_valid`=0, `rsp_res`=0, `rsp_err`=0, `busy`=0.
  - Any in-flight unit result is discarded.

## Timing
- All outputs except `req_ready` are registered. `req_ready` = (state==IDLE) && !rst.
- Accept edge E0 (req_valid && req_ready) → ISSUE during the cycle after E0.
- A standard unit pulses `done` two edges after it samples `start`:
  - E1: unit samples start.
  - Cycle after E2: `done` visible.
  - E3: captured.
  - Cycle after E3: `rsp_valid`=1.
- Request-to-response latency: 4 cycles with a standard unit. Minimum back-to-back request spacing: 5 cycles when `rsp_ready` is tied high.
- Invalid opcode: `rsp_valid` rises in the cycle after E0.
- `done` and timeout expiring in the same cycle: `done` wins; result is captured with err=0.

## Configuration
- Macro: `ALU_DISPATCH_TIMEOUT_EN`.
- Defined:
  - An 8-bit timer counts WAIT cycles.
  - If `unit_done[op]` is not seen within TIMEOUT WAIT cycles, go to RESP with `rsp_res`=16'h0000 and `rsp_err`=1.
- Undefined:
  - No timer logic.
  - WAIT persists until `done` arrives.
  - `rsp_err` is raised only for an invalid opcode.

## Test plan
- Op=0 (AND unit), a=8'hF0, b=8'h3C, `rsp_ready`=1 → `unit_start`=4'b0001 for exactly 1 cycle. `rsp_valid` 4 cycles after accept with `rsp_res`=16'h0030 and `rsp_err`=0.
- Op=5 with NUM_UNITS=4 → no `unit_start` bit asserts. `rsp_valid` the next cycle with `rsp_res`=0 and `rsp_err`=1.
- Backpressure: hold `rsp_ready`=0 for 10 cycles → `rsp_valid`, `rsp_res` and `rsp_err` stay stable and `req_ready`=0 throughout. Raise `rsp_ready` → IDLE next cycle.
- Timeout (macro defined, TIMEOUT=15): stub unit never pulses `done` → `rsp_err`=1 and `rsp_res`=0 after 15 WAIT cycles. A later stray `done` produces no response.
- Pulse `unit_done` on unit 2 while waiting on unit 1 → ignored. Then unit 1 `done` with res=16'h00AA → `rsp_res`=16'h00AA.
- Assert `rst` asynchronously mid-WAIT → outputs reset immediately. After release, the next request completes normally.
